// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token, seedable via load/D.
// Issues a registered one-hot grant that is held while requested, up to MAX_HOLD cycles.
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] D,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [N-1:0] token,
    output logic         err
);

    localparam int HW = $clog2(MAX_HOLD + 2);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  token_q, token_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          err_q, err_d;

    logic [N-1:0]  pick;
    logic [N-1:0]  next_start;
    logic          d_onehot;
    logic          keep;

    function automatic logic [N-1:0] rot(input logic [N-1:0] x);
        return {x[N-2:0], x[N-1]};
    endfunction

    // Rotate req so that 'start' lands on bit 0, isolate the lowest set bit,
    // then rotate the result back into place.
    function automatic logic [N-1:0] search(input logic [N-1:0] start,
                                            input logic [N-1:0] r);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rr;
        logic [N-1:0]   low;
        int             s;
        s   = 0;
        for (int i = 0; i < N; i++) begin
            if (start[i]) s = i;
        end
        dbl = {r, r} >> s;
        rr  = dbl[N-1:0];
        low = rr & (~rr + N'(1));
        dbl = {low, low} << s;
        return dbl[2*N-1:N];
    endfunction

    assign d_onehot   = (D != '0) && ((D & (D - N'(1))) == '0);
    assign next_start = rot(gnt_q);
    assign keep       = ((req & gnt_q) != '0) &&
                        ((MAX_HOLD == 0) || (hold_q < HW'(MAX_HOLD)));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        token_d = token_q;
        hold_d  = hold_q;
        err_d   = 1'b0;
        pick    = '0;
        if (load) begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
            if (d_onehot) token_d = D;
            else          err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != '0) begin
                        pick    = search(token_q, req);
                        gnt_d   = pick;
                        token_d = pick;
                        hold_d  = HW'(1);
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    if (keep) begin
                        if (MAX_HOLD != 0) hold_d = hold_q + HW'(1);
                    end else begin
                        // Release or timeout: hand over directly, no idle bubble.
                        pick = search(next_start, req);
                        if (pick != '0) begin
                            gnt_d   = pick;
                            token_d = pick;
                            hold_d  = HW'(1);
                        end else begin
                            gnt_d   = '0;
                            token_d = next_start;
                            hold_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            token_q <= N'(1);
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            token_q <= token_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign token     = token_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: vector table, directed corner sequences
// and randomized traffic against an index-based reference model.
module tb_ring_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [N-1:0] D = '0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [N-1:0] token;
    logic         err;

    int checks = 0;
    int errors = 0;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .load(load), .D(D), .req(req),
        .gnt(gnt), .gnt_valid(gnt_valid), .token(token), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: owner/token as integer indices, hold as a plain count.
    bit m_busy;
    int m_own, m_tok, m_hold;
    bit m_err;

    function automatic int find_from(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_tok = 0; m_hold = 0; m_err = 0;
    endtask

    task automatic model_step();
        int g;
        m_err = 0;
        if (load) begin
            m_busy = 0; m_hold = 0;
            if ($countones(D) == 1) begin
                for (int i = 0; i < N; i++) if (D[i]) m_tok = i;
            end else begin
                m_err = 1;
            end
        end else if (!m_busy) begin
            g = find_from(m_tok, req);
            if (g >= 0) begin
                m_busy = 1; m_own = g; m_tok = g; m_hold = 1;
            end
        end else if (req[m_own] && m_hold < MH) begin
            m_hold++;
        end else begin
            g = find_from((m_own + 1) % N, req);
            if (g >= 0) begin
                m_own = g; m_tok = g; m_hold = 1;
            end else begin
                m_busy = 0; m_tok = (m_own + 1) % N; m_hold = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        return m_busy ? N'(1 << m_own) : '0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act[N-1:0], expv[N-1:0], $time);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".gnt"}, 32'(gnt), 32'(exp_gnt()));
        chk({nm, ".gnt_valid"}, 32'(gnt_valid), 32'(m_busy));
        chk({nm, ".token"}, 32'(token), 32'(1 << m_tok));
        chk({nm, ".err"}, 32'(err), 32'(m_err));
    endtask

    // Drive inputs just after a falling edge, let one rising edge pass, compare.
    task automatic tick(input string nm, input logic [N-1:0] r, input logic l,
                        input logic [N-1:0] d);
        req = r; load = l; D = d;
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk_model(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '1; load = 1'b0; D = '0;
        @(negedge clk);
        chk("rst.gnt", 32'(gnt), 0);
        chk("rst.gnt_valid", 32'(gnt_valid), 0);
        chk("rst.token", 32'(token), 1);
        chk("rst.err", 32'(err), 0);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] r;
        logic         l;
        logic [N-1:0] d;
        logic [N-1:0] g;
        logic [N-1:0] t;
        logic         e;
    } vec_t;

    vec_t tbl[12];
    logic [N-1:0] rq;
    int unsigned rv;

    initial begin
        tbl[0]  = '{4'b0101, 1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b0};
        tbl[1]  = '{4'b0101, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[4]  = '{4'b0110, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b0};
        tbl[5]  = '{4'b1001, 1'b0, 4'b0000, 4'b1000, 4'b1000, 1'b0};
        tbl[6]  = '{4'b1000, 1'b0, 4'b0000, 4'b1000, 4'b1000, 1'b0};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0110, 4'b0000, 4'b1000, 1'b1};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[9]  = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b1};
        tbl[10] = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b0};
        tbl[11] = '{4'b0100, 1'b0, 4'b0000, 4'b0100, 4'b0100, 1'b0};

        model_reset();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick("tbl.model", tbl[i].r, tbl[i].l, tbl[i].d);
            chk($sformatf("tbl%0d.gnt", i), 32'(gnt), 32'(tbl[i].g));
            chk($sformatf("tbl%0d.token", i), 32'(token), 32'(tbl[i].t));
            chk($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].e));
            chk($sformatf("tbl%0d.valid", i), 32'(gnt_valid), 32'(|tbl[i].g));
        end

        // First grant after reset release, then fair rotation under full load.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tick("fair.model", 4'b1111, 1'b0, 4'b0000);
            chk($sformatf("fair%0d.gnt", c), 32'(gnt), 32'(1 << ((c / 8) % 4)));
        end

        // Lone requester times out and is re-granted without a gap.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tick("solo.model", 4'b0001, 1'b0, 4'b0000);
            chk("solo.gnt", 32'(gnt), 1);
        end

        // Early release to nobody: token parks after the old owner.
        do_reset();
        tick("rel.seed", 4'b0000, 1'b1, 4'b0010);
        tick("rel.grant", 4'b0010, 1'b0, 4'b0000);
        chk("rel.gnt1", 32'(gnt), 32'(4'b0010));
        tick("rel.drop", 4'b0000, 1'b0, 4'b0000);
        chk("rel.gnt0", 32'(gnt), 0);
        chk("rel.token", 32'(token), 32'(4'b0100));

        // Asynchronous reset between edges while granted.
        tick("async.seed", 4'b0000, 1'b1, 4'b1000);
        tick("async.grant", 4'b1000, 1'b0, 4'b0000);
        chk("async.pre", 32'(gnt), 32'(4'b1000));
        #2 rst = 1'b1;
        #1;
        chk("async.gnt", 32'(gnt), 0);
        chk("async.token", 32'(token), 1);
        chk("async.valid", 32'(gnt_valid), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with occasional seeds (some malformed) and resets.
        rq = '0;
        for (int it = 0; it < 1500; it++) begin
            rv = $urandom;
            if (rv % 4 == 0) rq = N'($urandom);
            if (rv % 211 == 7) begin
                #2 rst = 1'b1;
                #1;
                chk("rnd.async.gnt", 32'(gnt), 0);
                chk("rnd.async.token", 32'(token), 1);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end else if (rv % 37 == 3) begin
                if ((rv >> 8) % 3 == 0) tick("rnd.load", rq, 1'b1, N'($urandom));
                else tick("rnd.load", rq, 1'b1, N'(1 << ((rv >> 10) % N)));
            end else begin
                tick("rnd", rq, 1'b0, 4'b0000);
            end
            chk("rnd.onehot", 32'($countones(gnt) <= 1), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
Round-robin arbiter that shares one resource among N requesters. Priority is tracked by a one-hot rotating token, which is ring-counter style and can be seeded with load/D. The block issues a registered one-hot grant and holds it while the owner keeps requesting, up to a hold limit. It sits between the requesters and the shared datapath, and it sequences ownership of that datapath.

Parameters:
N, 4, number of requesters; also the width of D, req, gnt and token (N >= 2).
MAX_HOLD, 8, maximum consecutive cycles one grant stays asserted while its req stays high; 0 = unlimited.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
load  input  1  seed the token from D; aborts any current grant.
D  input  N  token seed; must be one-hot.
req  input  N  request vector; bit i = requester i.
gnt  output  N  registered one-hot grant, or all-zero.
gnt_valid  output  1  equals |gnt.
token  output  N  current one-hot priority pointer.
err  output  1  one-cycle pulse: load seen with a non-one-hot D.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-grant):
  - gnt=0, gnt_valid=0, token=1 (bit 0), err=0.
  - state=IDLE, hold_cnt=0.
- States: IDLE (no grant) and GRANT (gnt one-hot).
- Rotation: rot(x) moves bit i to bit i+1, with bit N-1 wrapping to bit 0.
- Search(start): first asserted req bit, scanning from start upward with wrap, inclusive of start.
- Priority at each edge: rst > load > arbitration.
- load=1, D one-hot:
  - token<=D, gnt<=0, hold_cnt<=0, state<=IDLE, err<=0.
  - req is ignored that cycle; the earliest grant appears one edge later.
- load=1, D not one-hot (zero or more than one bit set):
  - token unchanged, gnt<=0, state<=IDLE, err<=1 for exactly one cycle.
- IDLE, req!=0:
  - g=Search(token); gnt<=g, token<=g, hold_cnt<=1, state<=GRANT.
  - Latency: req sampled at edge k gives gnt visible after edge k.
- IDLE, req==0: hold all state.
- GRANT, req&gnt != 0 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD): keep gnt, hold_cnt<=hold_cnt+1.
- GRANT, release (req&gnt==0) or timeout (MAX_HOLD!=0, hold_cnt==MAX_HOLD, req still high):
  - g=Search(rot(gnt)).
  - If found: gnt<=g, token<=g, hold_cnt<=1, state stays GRANT. No idle bubble between owners.
  - If none: gnt<=0, token<=rot(gnt), state<=IDLE.
  - On timeout with only the owner requesting, Search wraps to the owner; it is re-granted with hold_cnt=1.
- Grant width limit: a single grant is asserted for at most MAX_HOLD consecutive cycles before re-arbitration.
- gnt is never multi-hot.
- gnt_valid is combinational from the gnt register.
- Reset deasserted with load=1: load applies on the first edge after deassertion.

Test Plan:
- Reset: hold rst=1 with req=1111 → gnt=0000, gnt_valid=0, token=0001, err=0. After release, the next edge gives gnt=0001.
- Seed: load=1, D=1000, req=0101 for one cycle, then load=0 → token=1000, gnt=0000. Next edge gives gnt=0001 and token=0001 (search wraps from bit 3).
- Fairness with MAX_HOLD=8: req=1111 constant → gnt=0001 for 8 cycles, then 0010, 0100 and 1000 for 8 cycles each, then 0001 again. No gap between grants.
- Early release: gnt=0010, then req changes to 1001 → next edge gives gnt=1000. With req=0000 instead, gnt=0000 and token=0100.
- Bad seed: load=1, D=0110 while gnt=0100 → gnt=0000, token unchanged, err=1 for one cycle only. A simultaneous req does not produce a grant that edge.
- Async reset mid-grant: assert rst between clock edges while gnt=1000 → gnt=0000 and token=0001 immediately, without waiting for a clock edge.
